// File: rtl/preflector_pipe.sv
// preflector_pipe: reflector datapath (shuffle, MixColumns, tweakey add,
// inverse shuffle) behind a STAGES-deep valid/ready register pipeline.
// Cells are w = n/16 bits wide, and cell 0 is the most significant cell.
// Legal configurations: n in {64, 128}, STAGES in 1..4.

// One matrix column of MixColumns. Each output row is the XOR of the other
// three rows, each rotated by the amount that goes with its row distance.
module preflector_mc_col #(
    parameter int w  = 8,
    parameter int ra = 0,
    parameter int rb = 0,
    parameter int rc = 0
) (
    input  logic [0:3][w-1:0] col_in,
    output logic [0:3][w-1:0] col_out
);
    // Rotation per row distance (k - r) mod 4; distance 0 is never used.
    localparam int rtab [4] = '{0, ra, rb, rc};

    function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input int r);
        int s;
        s = r % w;
        if (s == 0) return x;
        return (x << s) | (x >> (w - s));
    endfunction

    // Combine the other three rows of this column.
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (k != r)
                    col_out[r] = col_out[r] ^ rotl(col_in[k], rtab[(k - r + 4) % 4]);
    end
endmodule

// One pipeline slot. Only the valid bit is reset or flushed; the payload
// registers capture data only when a real transaction moves in.
module preflector_slot #(
    parameter int dw = 128,
    parameter int tw = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          load,
    input  logic          src_vld,
    input  logic [dw-1:0] src_dat,
    input  logic [tw-1:0] src_tag,
    output logic          vld,
    output logic [dw-1:0] dat,
    output logic [tw-1:0] tag
);
    // Valid bit: async reset, sync flush, else follow the source on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        vld <= 1'b0;
        else if (flush) vld <= 1'b0;
        else if (load)  vld <= src_vld;
    end

    // Payload: no reset; held steady whenever the slot is not loading.
    always_ff @(posedge clk) begin
        if (load && src_vld) begin
            dat <= src_dat;
            tag <= src_tag;
        end
    end
endmodule

module preflector_pipe #(
    parameter int          n        = 128,
    parameter logic [0:63] perm     = 64'b0,
    parameter logic [0:63] inv_perm = 64'b0,
    parameter logic [0:11] MC_abc   = 12'b0,
    parameter int          STAGES   = 2,
    parameter int          TAGW     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [n-1:0]    indata,
    input  logic [n-1:0]    tk,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [n-1:0]    outdata,
    output logic [TAGW-1:0] out_tag,
    output logic [2:0]      occupancy
);
    localparam int w = n / 16;

    // Packed [0:15] puts cell 0 in the MSBs, so the cell view is a plain cast.
    typedef logic [0:15][w-1:0] cells_t;

    // out cell i = in cell p[i]; p entry i is the 4-bit field starting at bit 4i.
    function automatic cells_t shuffle(input cells_t x, input logic [0:63] p);
        cells_t y;
        for (int i = 0; i < 16; i++) y[i] = x[p[4*i +: 4]];
        return y;
    endfunction

    cells_t                 sh_cells, tk_cells, mix_cells, front_cells;
    logic [0:3][0:3][w-1:0] col_in, col_out;   // [column][row]

    assign sh_cells = shuffle(cells_t'(indata), perm);
    assign tk_cells = cells_t'(tk);

    // Regroup the shuffled state by column for the MixColumns units.
    always_comb begin
        col_in = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                col_in[c][r] = sh_cells[4*r + c];
    end

    genvar gc;
    for (gc = 0; gc < 4; gc++) begin : g_col
        preflector_mc_col #(
            .w (w),
            .ra(int'(MC_abc[0:3])),
            .rb(int'(MC_abc[4:7])),
            .rc(int'(MC_abc[8:11]))
        ) u_col (
            .col_in (col_in[gc]),
            .col_out(col_out[gc])
        );
    end

    // Back to row-major cell order, adding the tweakey.
    always_comb begin
        mix_cells = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mix_cells[4*r + c] = col_out[c][r] ^ tk_cells[4*r + c];
    end

    // A single-slot pipe must finish the whole function before its only
    // register; deeper pipes move the inverse shuffle behind slot 1.
    assign front_cells = (STAGES == 1) ? shuffle(mix_cells, inv_perm) : mix_cells;

    logic [STAGES:1]         vld_pipe, adv, load;
    logic [STAGES:1][n-1:0]  sdat;
    logic [STAGES:1][TAGW-1:0] stag;
    logic                    in_fire;

    // Backpressure chain: a slot advances when it holds data and its
    // successor is empty or advancing too; the last slot drains on out_ready.
    always_comb begin
        adv  = '0;
        load = '0;
        adv[STAGES] = vld_pipe[STAGES] & out_ready;
        for (int k = STAGES - 1; k >= 1; k--)
            adv[k] = vld_pipe[k] & (~vld_pipe[k+1] | adv[k+1]);
        for (int k = 1; k <= STAGES; k++)
            load[k] = ~vld_pipe[k] | adv[k];
    end

    // Flush wins over a concurrent input, but still reports ready so the
    // producer sees its beat consumed (and discarded).
    assign in_ready = flush | load[1];
    assign in_fire  = in_valid & in_ready & ~flush;

    genvar gs;
    for (gs = 1; gs <= STAGES; gs++) begin : g_slot
        logic [n-1:0]    src_dat;
        logic [TAGW-1:0] src_tag;
        logic            src_vld;

        if (gs == 1) begin : g_feed_front
            assign src_dat = front_cells;
            assign src_tag = in_tag;
            assign src_vld = in_fire;
        end else if (gs == 2) begin : g_feed_inv
            assign src_dat = shuffle(cells_t'(sdat[1]), inv_perm);
            assign src_tag = stag[1];
            assign src_vld = vld_pipe[1];
        end else begin : g_feed_copy
            assign src_dat = sdat[gs-1];
            assign src_tag = stag[gs-1];
            assign src_vld = vld_pipe[gs-1];
        end

        preflector_slot #(.dw(n), .tw(TAGW)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .load   (load[gs]),
            .src_vld(src_vld),
            .src_dat(src_dat),
            .src_tag(src_tag),
            .vld    (vld_pipe[gs]),
            .dat    (sdat[gs]),
            .tag    (stag[gs])
        );
    end

    // Count of occupied slots, straight from the valid registers.
    always_comb begin
        occupancy = '0;
        for (int k = 1; k <= STAGES; k++)
            occupancy = occupancy + {2'b00, vld_pipe[k]};
    end

    assign out_valid = vld_pipe[STAGES];
    assign outdata   = sdat[STAGES];
    assign out_tag   = stag[STAGES];
endmodule

// File: tb/tb_preflector_pipe.sv
// Bench for preflector_pipe: a QARMA-128 style 3-stage instance driven with
// directed and random traffic against a cell-level reference model through a
// scoreboard, plus a small n=64 single-stage instance with known vectors.
`timescale 1ns/1ps
module tb_preflector_pipe;
    localparam int ST = 3;
    localparam logic [0:63] PERM  = 64'h0B6DA1C75E38F492;
    localparam logic [0:63] IPERM = 64'h05FAD827BE41639C;
    localparam int TAU  [16] = '{0, 11, 6, 13, 10, 1, 12, 7, 5, 14, 3, 8, 15, 4, 9, 2};
    localparam int ITAU [16] = '{0, 5, 15, 10, 13, 8, 2, 7, 11, 14, 4, 1, 6, 3, 9, 12};
    localparam int ROT  [4]  = '{0, 1, 4, 5};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] indata, tk, outdata;
    logic [3:0]   in_tag, out_tag;
    logic [2:0]   occupancy;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0]  b_indata, b_tk, b_outdata;
    logic [1:0]   b_in_tag, b_out_tag;
    logic [2:0]   b_occ;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tag;
        int           cyc;
        bit           lat;
    } exp_t;
    exp_t sb_q [$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    preflector_pipe #(.n(128), .perm(PERM), .inv_perm(IPERM), .MC_abc(12'h145),
                      .STAGES(ST), .TAGW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .indata(indata), .tk(tk), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .outdata(outdata), .out_tag(out_tag), .occupancy(occupancy)
    );

    preflector_pipe #(.n(64), .perm(64'h0123456789ABCDEF), .inv_perm(64'h0123456789ABCDEF),
                      .MC_abc(12'h000), .STAGES(1), .TAGW(2)) dut_b (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .indata(b_indata), .tk(b_tk), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .outdata(b_outdata), .out_tag(b_out_tag), .occupancy(b_occ)
    );

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
        logic [15:0] d;
        d = {x, x} << (r % 8);
        return d[15:8];
    endfunction

    // Cell-level model: shuffle, column mix, tweakey add, inverse shuffle.
    function automatic logic [127:0] ref_model(input logic [127:0] x, input logic [127:0] k);
        logic [7:0] c [16];
        logic [7:0] s [16];
        logic [7:0] m [16];
        logic [127:0] y;
        logic [7:0] acc;
        for (int i = 0; i < 16; i++) c[i] = x[127 - 8*i -: 8];
        for (int i = 0; i < 16; i++) s[i] = c[TAU[i]];
        for (int r = 0; r < 4; r++)
            for (int col = 0; col < 4; col++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    if (j != r) acc = acc ^ rotl8(s[4*j + col], ROT[(j - r + 4) % 4]);
                m[4*r + col] = acc ^ k[127 - 8*(4*r + col) -: 8];
            end
        y = '0;
        for (int i = 0; i < 16; i++) y[127 - 8*i -: 8] = m[ITAU[i]];
        return y;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        cmp_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One input cycle: drive at the falling edge, then log what will transfer.
    task automatic drive(input bit v, input logic [127:0] d, input logic [127:0] k,
                         input logic [3:0] t, input bit ordy, input bit fl, input bit lat);
        @(negedge clk);
        in_valid  = v;
        indata    = d;
        tk        = k;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (fl) sb_q.delete();
        else if (v && in_ready) sb_q.push_back('{ref_model(d, k), t, cyc, lat});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, '0, '0, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every accepted output must match the scoreboard head.
    always begin
        @(negedge clk);
        #2;
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_output: got %h tag %h, expected no output", outdata, out_tag);
            end else begin
                mon_e = sb_q.pop_front();
                chk("outdata", outdata, mon_e.data);
                chk("out_tag", {124'b0, out_tag}, {124'b0, mon_e.tag});
                if (mon_e.lat) chk("latency", cyc - mon_e.cyc, ST);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        in_valid = 0; flush = 0; out_ready = 0; indata = '0; tk = '0; in_tag = '0;
        b_in_valid = 0; b_out_ready = 0; b_indata = '0; b_tk = '0; b_in_tag = '0;

        // Reset state, checked between edges while rst is held.
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("ready_after_rst", in_ready, 1);

        // n=64 single-stage instance with hand-derived vectors.
        @(negedge clk);
        b_in_valid = 1; b_indata = 64'h1000_0000_0000_0000; b_tk = '0; b_in_tag = 2'd1; b_out_ready = 1;
        @(negedge clk);
        b_in_valid = 1; b_indata = '0; b_tk = 64'hDEAD_BEEF_0123_4567; b_in_tag = 2'd2;
        #1;
        chk("b_vec1_valid", b_out_valid, 1);
        chk("b_vec1_data", b_outdata, 64'h0000_1000_1000_1000);
        chk("b_vec1_tag", b_out_tag, 2'd1);
        @(negedge clk);
        b_in_valid = 0;
        #1;
        chk("b_vec2_valid", b_out_valid, 1);
        chk("b_vec2_data", b_outdata, 64'hDEAD_BEEF_0123_4567);
        chk("b_vec2_tag", b_out_tag, 2'd2);
        @(negedge clk);
        #1;
        chk("b_empty", b_out_valid, 0);

        // 32 back-to-back inputs, tags 0..15 twice, sink always ready.
        for (int i = 0; i < 32; i++) begin
            d = (i == 5 || i == 6) ? 128'b0 : rnd128();
            drive(1'b1, d, (i == 6) ? 128'b0 : rnd128(), 4'(i % 16), 1'b1, 1'b0, 1'b1);
            chk("b2b_in_ready", in_ready, 1);
        end
        idle(ST + 1);
        chk("b2b_drained", sb_q.size(), 0);

        // Sink stalls for 5 cycles while the source keeps streaming.
        drive(1'b1, rnd128(), rnd128(), 4'h1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, rnd128(), rnd128(), 4'h2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rnd128(), rnd128(), 4'(3 + i), 1'b0, 1'b0, 1'b0);
            if (i >= 1) begin
                chk("stall_occupancy", occupancy, 3);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_outdata", outdata, sb_q[0].data);
                chk("stall_out_tag", out_tag, sb_q[0].tag);
            end
        end
        idle(ST + 2);
        chk("stall_drained", sb_q.size(), 0);

        // Flush with two in flight and a concurrent input.
        drive(1'b1, rnd128(), rnd128(), 4'hA, 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd128(), rnd128(), 4'hB, 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd128(), rnd128(), 4'hC, 1'b0, 1'b1, 1'b0);
        chk("flush_occ_before", occupancy, 2);
        chk("flush_in_ready", in_ready, 1);
        drive(1'b0, '0, '0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_occ_after", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        drive(1'b1, rnd128(), rnd128(), 4'hD, 1'b1, 1'b0, 1'b1);
        drive(1'b1, rnd128(), rnd128(), 4'hE, 1'b1, 1'b0, 1'b1);
        idle(ST + 2);
        chk("flush_drained", sb_q.size(), 0);

        // Asynchronous reset with the pipe full.
        for (int i = 0; i < 3; i++) drive(1'b1, rnd128(), rnd128(), 4'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("full_before_rst", occupancy, 3);
        #1 rst = 1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_occupancy", occupancy, 0);
        sb_q.delete();
        #1 rst = 0;
        drive(1'b1, rnd128(), rnd128(), 4'h7, 1'b1, 1'b0, 1'b1);
        chk("rst_release_ready", in_ready, 1);
        idle(ST + 2);
        chk("rst_drained", sb_q.size(), 0);

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            bit v, ordy, fl;
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 39) == 0);
            d    = ($urandom_range(0, 15) == 0) ? 128'b0 : rnd128();
            drive(v, d, rnd128(), 4'($urandom_range(0, 15)), ordy, fl, 1'b0);
        end

        // Bounded drain.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
        chk("final_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/preflector_pipe.md
PREFLECTOR_PIPE -- requirements
Module: preflector_pipe

Interface
REQ-001 SHALL have parameter n, default 128, datapath width; 16 cells of w=n/16 bits; n SHALL be 64 or 128.
REQ-002 SHALL have parameter perm, default 64'b0, sixteen 4-bit forward shuffle indices; entry i is bits [4i:4i+3] of the [0:63] vector.
REQ-003 SHALL have parameter inv_perm, default 64'b0, sixteen 4-bit inverse shuffle indices, same layout as perm.
REQ-004 SHALL have parameter MC_abc, default 12'b0, three 4-bit rotation amounts a, b, c in [0:11] order.
REQ-005 SHALL have parameter STAGES, default 2, pipeline depth; legal range 1..4.
REQ-006 SHALL have parameter TAGW, default 4, sideband tag width.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 flush  input  1  synchronous clear of all in-flight data.
REQ-010 in_valid  input  1  input transaction present.
REQ-011 in_ready  output  1  block accepts input this cycle.
REQ-012 indata  input  n  state to reflect.
REQ-013 tk  input  n  tweakey for this transaction, sampled with indata.
REQ-014 in_tag  input  TAGW  sideband, returned unmodified with the result.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 outdata  output  n  reflected state.
REQ-018 out_tag  output  TAGW  tag of the transaction on outdata.
REQ-019 occupancy  output  3  number of valid stages, 0..STAGES.

Function
REQ-020 Cell i SHALL be bits [n-1-w*i -: w]; cell 0 is the MSB cell; matrix view: row i/4, column i%4.
REQ-021 Shuffle with p SHALL set out cell i = in cell p[i].
REQ-022 MixColumns SHALL compute out[r][col] = XOR over k!=r of rotl_w(in[k][col], R[(k-r) mod 4]), with R[1]=a, R[2]=b, R[3]=c; rotation taken mod w.
REQ-023 Result SHALL equal shuffle(inv_perm, MixColumns(shuffle(perm, indata)) XOR tk).
REQ-024 Transfer SHALL occur on in_valid&&in_ready at input and out_valid&&out_ready at output; no other condition moves data.
REQ-025 Pipeline SHALL hold STAGES register slots, each with data, tag and valid bit; shuffle+MixColumns+tk XOR SHALL be evaluated before slot 1, inverse shuffle before slot 1 when STAGES=1, else between slots 1 and 2.
REQ-026 Slot k SHALL load from slot k-1 when slot k is empty or slot k is advancing this cycle; last slot advances on out_ready.
REQ-027 in_ready SHALL be !valid[1] || advance[1], combinationally dependent on out_ready; no bubbles when out_ready stays high.
REQ-028 Latency from input transfer to out_valid SHALL be exactly STAGES cycles with out_ready held high; throughput one per cycle.
REQ-029 out_valid, outdata, out_tag SHALL be driven from the last slot only; outdata and out_tag SHALL be stable while out_valid&&!out_ready.
REQ-030 Ordering SHALL be strictly FIFO; no transaction dropped or duplicated except by flush or rst.
REQ-031 occupancy SHALL equal the count of set valid bits after each edge.
REQ-032 flush SHALL clear all valid bits at the next edge, take priority over any simultaneous input transfer (that input is discarded), and hold in_ready=1 during the flush cycle.
REQ-033 Data registers SHALL NOT be reset or cleared; only valid bits are.

Reset
REQ-034 rst asserted SHALL clear all valid bits immediately, forcing out_valid=0 and occupancy=0 without a clock edge.
REQ-035 After rst deasserts, in_ready SHALL be 1 and the first input SHALL be accepted on the first rising edge.
REQ-036 rst mid-operation SHALL discard all in-flight transactions; no partial result SHALL appear afterward.

Verification
REQ-037 n=64, identity perm/inv_perm, MC_abc=0, tk=0, indata=64'h1000_0000_0000_0000 -> outdata=64'h0000_1000_1000_1000 after STAGES cycles.
REQ-038 Any config, indata=0, tk=X -> outdata = shuffle(inv_perm, X); tk=0, indata=0 -> outdata=0.
REQ-039 QARMA-128 parameters, 32 back-to-back inputs with tags 0..15 repeated, out_ready held high -> 32 results in order, one per cycle, matching a golden model.
REQ-040 out_ready low for 5 cycles with STAGES=3 streaming -> occupancy saturates at 3, in_ready=0, outdata/out_tag frozen, no loss after release.
REQ-041 flush with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, flushed and concurrent inputs never emerge.
REQ-042 rst asserted between edges with occupancy=STAGES -> out_valid=0 immediately; after release, a single input emerges exactly STAGES cycles later.
